// File: rtl/multiplier_3bit_arbiter.sv
// Two-requester front end for a shared 3x3 unsigned multiplier: round-robin
// arbitration, one-cycle compute, and a held response slot per requester.

module multiplier_3bit (
  input  logic [2:0] a_i,
  input  logic [2:0] b_i,
  output logic [5:0] p_o
);
  assign p_o = {3'b000, a_i} * {3'b000, b_i};
endmodule

module multiplier_3bit_arbiter #(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [2:0] req0_a,
  input  logic [2:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_a,
  input  logic [2:0] req1_b,
  output logic       req1_ready,
  output logic       rsp0_valid,
  output logic [5:0] rsp0_p,
  input  logic       rsp0_ready,
  output logic       rsp1_valid,
  output logic [5:0] rsp1_p,
  input  logic       rsp1_ready,
  output logic       busy,
  output logic [7:0] done_count
);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t     state_q;
  logic       prio_q;
  logic       op_id_q;
  logic [2:0] op_a_q;
  logic [2:0] op_b_q;
  logic       rsp0_valid_q;
  logic       rsp1_valid_q;
  logic [5:0] rsp0_p_q;
  logic [5:0] rsp1_p_q;
  logic       busy_q;
  logic [7:0] cnt_q;

  logic       elig0_s;
  logic       elig1_s;
  logic       grant_v_s;
  logic       grant_id_s;
  logic [5:0] mult_p_s;

  multiplier_3bit u_mult (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (mult_p_s)
  );

  // A requester with an unconsumed result is held off until its slot frees.
  assign elig0_s    = req0_valid & ~rsp0_valid_q;
  assign elig1_s    = req1_valid & ~rsp1_valid_q;
  assign grant_v_s  = (state_q == IDLE) & (elig0_s | elig1_s);
  assign grant_id_s = (elig0_s & elig1_s) ? prio_q : elig1_s;

  assign req0_ready = ~rst & grant_v_s & ~grant_id_s;
  assign req1_ready = ~rst & grant_v_s &  grant_id_s;

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_p     = rsp0_p_q;
  assign rsp1_p     = rsp1_p_q;
  assign busy       = busy_q;
  assign done_count = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prio_q       <= PRIO_INIT;
      op_id_q      <= 1'b0;
      op_a_q       <= 3'd0;
      op_b_q       <= 3'd0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_p_q     <= 6'd0;
      rsp1_p_q     <= 6'd0;
      busy_q       <= 1'b0;
      cnt_q        <= 8'd0;
    end else begin
      // Consumption may coincide with an accept or a result for the other side.
      if (rsp0_valid_q && rsp0_ready) begin
        rsp0_valid_q <= 1'b0;
      end
      if (rsp1_valid_q && rsp1_ready) begin
        rsp1_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (grant_v_s) begin
            op_a_q  <= grant_id_s ? req1_a : req0_a;
            op_b_q  <= grant_id_s ? req1_b : req0_b;
            op_id_q <= grant_id_s;
            prio_q  <= ~grant_id_s;
            state_q <= CALC;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        CALC: begin
          if (op_id_q) begin
            rsp1_valid_q <= 1'b1;
            rsp1_p_q     <= mult_p_s;
          end else begin
            rsp0_valid_q <= 1'b1;
            rsp0_p_q     <= mult_p_s;
          end
          cnt_q   <= cnt_q + 8'd1;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_3bit_arbiter.sv
// Self-checking bench: a per-cycle rule model plus directed tables and sequences.

module tb_multiplier_3bit_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [2:0] req0_a = 3'd0, req0_b = 3'd0, req1_a = 3'd0, req1_b = 3'd0;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [5:0] rsp0_p, rsp1_p;
  logic       rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic       busy;
  logic [7:0] done_count;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  multiplier_3bit_arbiter #(.PRIO_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_p(rsp0_p), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_p(rsp1_p), .rsp1_ready(rsp1_ready),
    .busy(busy), .done_count(done_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one pending job at a time, one outstanding result per side.
  bit         m_calc = 1'b0;
  bit   [1:0] m_out = 2'b00;
  bit         m_prio = 1'b0;
  bit         m_id = 1'b0;
  int         m_a = 0, m_b = 0;
  int         m_p[2] = '{0, 0};
  int         m_cnt = 0;

  always @(negedge clk) begin
    bit e0, e1, gv, gid;
    e0  = req0_valid && !m_out[0];
    e1  = req1_valid && !m_out[1];
    gv  = !m_calc && (e0 || e1);
    gid = (e0 && e1) ? m_prio : e1;
    if (mon_en) begin
      chk("mon_req0_ready", int'(req0_ready), int'(!rst && gv && !gid));
      chk("mon_req1_ready", int'(req1_ready), int'(!rst && gv && gid));
      chk("mon_rsp0_valid", int'(rsp0_valid), int'(m_out[0]));
      chk("mon_rsp1_valid", int'(rsp1_valid), int'(m_out[1]));
      chk("mon_rsp0_p", int'(rsp0_p), m_p[0]);
      chk("mon_rsp1_p", int'(rsp1_p), m_p[1]);
      chk("mon_busy", int'(busy), int'(m_calc));
      chk("mon_done_count", int'(done_count), m_cnt);
    end
    if (rst) begin
      m_calc = 1'b0; m_out = 2'b00; m_prio = 1'b0; m_id = 1'b0;
      m_a = 0; m_b = 0; m_p[0] = 0; m_p[1] = 0; m_cnt = 0;
    end else begin
      if (m_out[0] && rsp0_ready) m_out[0] = 1'b0;
      if (m_out[1] && rsp1_ready) m_out[1] = 1'b0;
      if (m_calc) begin
        m_out[m_id] = 1'b1;
        m_p[m_id]   = m_a * m_b;
        m_cnt       = (m_cnt + 1) % 256;
        m_calc      = 1'b0;
      end else if (gv) begin
        m_a    = gid ? int'(req1_a) : int'(req0_a);
        m_b    = gid ? int'(req1_b) : int'(req0_b);
        m_id   = gid;
        m_prio = !gid;
        m_calc = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Returns at the negedge before the accepting edge; ok=0 on timeout.
  task automatic wait_ready(input bit sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((sel ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk(sel ? "timeout_req1" : "timeout_req0", 0, 1);
  endtask

  task automatic do_one(input bit sel, input logic [2:0] a, input logic [2:0] b,
                        output int p, output int vld);
    bit ok;
    if (sel) begin req1_a = a; req1_b = b; req1_valid = 1'b1; rsp1_ready = 1'b1; end
    else     begin req0_a = a; req0_b = b; req0_valid = 1'b1; rsp0_ready = 1'b1; end
    wait_ready(sel, ok);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("calc_busy", int'(busy), 1);
    @(negedge clk);
    p   = sel ? int'(rsp1_p) : int'(rsp0_p);
    vld = sel ? int'(rsp1_valid) : int'(rsp0_valid);
  endtask

  typedef struct {
    bit         sel;
    logic [2:0] a;
    logic [2:0] b;
    int         p;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int p, vld, e;
    bit ok;
    vecs[0] = '{1'b0, 3'd7, 3'd2, 14};
    vecs[1] = '{1'b0, 3'd0, 3'd7, 0};
    vecs[2] = '{1'b1, 3'd7, 3'd7, 49};
    vecs[3] = '{1'b0, 3'd1, 3'd1, 1};
    vecs[4] = '{1'b1, 3'd3, 3'd5, 15};
    vecs[5] = '{1'b0, 3'd6, 3'd6, 36};
    vecs[6] = '{1'b1, 3'd2, 3'd3, 6};
    vecs[7] = '{1'b1, 3'd7, 3'd0, 0};

    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_req0_ready", int'(req0_ready), 0);
    chk("reset_rsp0_valid", int'(rsp0_valid), 0);
    chk("reset_rsp1_p", int'(rsp1_p), 0);
    chk("reset_done_count", int'(done_count), 0);
    do_reset();

    for (int i = 0; i < 8; i++) begin
      do_one(vecs[i].sel, vecs[i].a, vecs[i].b, p, vld);
      chk($sformatf("vec%0d_valid", i), vld, 1);
      chk($sformatf("vec%0d_p", i), p, vecs[i].p);
      if (i == 0) chk("single_done_count", int'(done_count), 1);
    end
    tick(); tick();

    // Contention: req0 wins first, req1 follows two cycles later.
    do_reset();
    req0_a = 3'd3; req0_b = 3'd5; req1_a = 3'd6; req1_b = 3'd6;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("cont_req0_ready", int'(req0_ready), 1);
    chk("cont_req1_ready", int'(req1_ready), 0);
    tick(); req0_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("cont_rsp0_p", int'(rsp0_p), 15);
    chk("cont_req1_ready_late", int'(req1_ready), 1);
    tick(); req1_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("cont_rsp1_p", int'(rsp1_p), 36);
    tick();
    req0_a = 3'd1; req0_b = 3'd1; req1_a = 3'd1; req1_b = 3'd1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("cont_prio_back_to_0", int'(req0_ready), 1);
    tick(); req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick(); tick();

    // Backpressure on response 0 while requester 1 keeps being served.
    do_reset();
    rsp0_ready = 1'b0;
    req0_a = 3'd4; req0_b = 3'd4; req0_valid = 1'b1;
    wait_ready(1'b0, ok);
    tick(); tick();
    req0_a = 3'd5;
    req1_a = 3'd2; req1_b = 3'd3; req1_valid = 1'b1;
    wait_ready(1'b1, ok);
    chk("bp_req0_ready_held", int'(req0_ready), 0);
    tick(); req1_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("bp_rsp1_p", int'(rsp1_p), 6);
    chk("bp_rsp0_p_stable", int'(rsp0_p), 16);
    chk("bp_req0_ready_still0", int'(req0_ready), 0);
    tick();
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    @(negedge clk);
    chk("bp_req0_after_pulse", int'(req0_ready), 1);
    tick(); req0_valid = 1'b0; rsp0_ready = 1'b1;
    tick(); tick();

    // Reset asserted during the compute cycle drops the job.
    req1_a = 3'd5; req1_b = 3'd5; req1_valid = 1'b1;
    wait_ready(1'b1, ok);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_req0_ready", int'(req0_ready), 0);
    chk("rst_mid_req1_ready", int'(req1_ready), 0);
    tick();
    @(negedge clk);
    chk("rst_mid_req1_ready_idle", int'(req1_ready), 0);
    chk("rst_mid_rsp1_valid", int'(rsp1_valid), 0);
    chk("rst_mid_done_count", int'(done_count), 0);
    chk("rst_mid_busy", int'(busy), 0);
    tick();
    rst = 1'b0; req1_valid = 1'b0;
    tick(); tick();

    // Counter wrap over 256 back-to-back jobs on requester 0.
    do_reset();
    rsp0_ready = 1'b1;
    req0_a = 3'($urandom_range(0, 7)); req0_b = 3'($urandom_range(0, 7));
    req0_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wait_ready(1'b0, ok);
      e = int'(req0_a) * int'(req0_b);
      tick();
      req0_a = 3'($urandom_range(0, 7)); req0_b = 3'($urandom_range(0, 7));
      if (i == 255) req0_valid = 1'b0;
      tick();
      @(negedge clk);
      chk("wrap_rsp0_valid", int'(rsp0_valid), 1);
      chk("wrap_rsp0_p", int'(rsp0_p), e);
    end
    chk("wrap_done_count", int'(done_count), 0);
    tick(); tick();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      tick();
      req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
      req0_a = 3'($urandom_range(0, 7)); req0_b = 3'($urandom_range(0, 7));
      req1_a = 3'($urandom_range(0, 7)); req1_b = 3'($urandom_range(0, 7));
      rsp0_ready = 1'($urandom_range(0, 1)); rsp1_ready = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiplier_3bit_arbiter.md
# multiplier_3bit_arbiter

Shares one `multiplier_3bit` instance between two requesters. Each requester has a valid/ready request channel and a valid/ready response channel. A round-robin arbiter picks one request at a time and latches its operands. A registered 6-bit product is returned to the requester that issued it. The block sits between the two operand sources and the single combinational multiplier, which it instantiates internally.

## Interface
Parameters:
- PRIO_INIT, default 0: requester holding priority after reset (0 or 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 presents an operand pair.
- req0_a  input  3  requester 0 operand A, unsigned.
- req0_b  input  3  requester 0 operand B, unsigned.
- req0_ready  output  1  request 0 accepted on this edge when high together with req0_valid.
- req1_valid, req1_a, req1_b, req1_ready: same as requester 0, for requester 1.
- rsp0_valid  output  1  rsp0_p holds a product for requester 0.
- rsp0_p  output  6  unsigned product req0_a*req0_b.
- rsp0_ready  input  1  requester 0 consumes the response.
- rsp1_valid, rsp1_p, rsp1_ready: same as response 0, for requester 1.
- busy  output  1  high while state is CALC.
- done_count  output  8  count of responses produced, wraps 255→0.

## Operation
- FSM with two states.
  - IDLE: arbitration. On an accept edge, go to CALC.
  - CALC: the multiplier computes from the latched operands. On the next edge, go back to IDLE unconditionally.
- Eligibility: requester X is eligible when reqX_valid=1 and rspX_valid=0. Each requester has at most one result outstanding.
- Grant in IDLE:
  - Only one requester eligible: grant it.
  - Both eligible: grant the requester named by the priority pointer `prio`.
  - Neither eligible: no grant.
- Ready signals:
  - reqX_ready = !rst and state==IDLE and grant==X. This is combinational from valid, rsp state and `prio`.
  - The other requester's ready is 0.
- Accept edge (reqX_valid and reqX_ready): latch operand A, operand B and the grant id into op registers, and set prio to the requester that was not granted.
- CALC edge:
  - Load the multiplier product of the op registers into rspX_p and set rspX_valid for the latched id.
  - Increment done_count by 1, modulo 256.
- Response hold: rspX_valid and rspX_p stay stable until the edge where rspX_valid and rspX_ready are both high. On that edge rspX_valid clears; rspX_p keeps its value.
- Arithmetic: 3×3 unsigned product. Full 6-bit result, no truncation. Maximum is 7×7=49 (6'b110001).
- Simultaneous events:
  - A response for X may be consumed on the same edge another request is accepted.
  - X itself becomes eligible again only in the cycle after rspX_valid clears.
- Reset (applies mid-operation too):
  - State goes to IDLE, prio=PRIO_INIT.
  - rsp0_valid=rsp1_valid=0, rsp0_p=rsp1_p=0.
  - Op registers 0, done_count=0, busy=0.
  - An in-flight CALC operation is dropped and produces no response.
  - req ready signals are 0 while rst=1.

## Timing
- Accept at edge N, state CALC during cycle N→N+1, rspX_valid high from edge N+1. Latency is 1 cycle after acceptance, visible in the second cycle counting the accept cycle.
- Throughput: at most one accept every 2 cycles. req ready signals are always 0 in CALC.
- busy=1 exactly during the CALC cycle.
- No combinational path from rspX_ready to any output other than through registered state.
- Reset values: req0_ready=req1_ready=0, rsp0_valid=rsp1_valid=0, rsp0_p=rsp1_p=6'b000000, busy=0, done_count=8'd0.

## Test plan
- Single request: req0 a=7, b=2, rsp0_ready=1. Required: rsp0_valid one edge after accept with rsp0_p=6'b001110 (14), and done_count=1.
- Contention with PRIO_INIT=0: req0 (3,5) and req1 (6,6) both valid in the same cycle. Required: req0 accepted first with rsp0_p=15. req1 accepted 2 cycles later with rsp1_p=36 (100100). prio=0 after the second grant.
- Backpressure: rsp0_ready=0 while rsp0_valid=1 and req0_valid stays high. Required:
  - req0_ready stays 0 and rsp0_p stays stable.
  - req1 (2,3) is still served with rsp1_p=6.
  - After rsp0_ready pulses, req0 is accepted on the following IDLE.
- Boundaries: operands (0,7) give rsp_p=0; (7,7) gives rsp_p=49 (6'b110001); (1,1) gives rsp_p=1.
- Reset mid-operation: assert rst during the CALC cycle of req1 (5,5). Required: no rsp1_valid, done_count=0, busy=0, and both req ready signals 0 while rst is high.
- Counter wrap: 256 back-to-back requests on req0 with rsp0_ready=1. Required: done_count wraps to 0 and every rsp0_p matches a*b.
